// File: rtl/icache_resp_pkg.sv
// Shared fetch-side definitions: IFB tag width, icache geometry, FSM states and line layout.
package icache_resp_pkg;

  localparam int IFB_ENTRY_WIDTH   = 4;
  localparam int ICACHE_SETS       = 64;
  localparam int ICACHE_LINE_WORDS = 4;
  localparam int ICACHE_TAG_W      = 32 - 4 - $clog2(ICACHE_SETS);

  typedef enum logic [1:0] {
    IC_IDLE,
    IC_LOOKUP,
    IC_MISS_REQ,
    IC_REFILL
  } ic_state_t;

  typedef logic [ICACHE_LINE_WORDS-1:0][31:0] ic_data_t;

  typedef struct packed {
    logic                    valid;
    logic [ICACHE_TAG_W-1:0] tag;
    ic_data_t                data;
  } icache_line_t;

endpackage

// File: rtl/icache_array.sv
// Flop-based direct-mapped line store: async read, single write, bulk valid clear.
module icache_array
  import icache_resp_pkg::*;
#(
  parameter int SETS  = ICACHE_SETS,
  parameter int TAG_W = 32 - 4 - $clog2(SETS),
  parameter int SET_W = $clog2(SETS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inv_all,
  input  logic [SET_W-1:0] rd_set,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output ic_data_t         rd_data,
  input  logic             wr_en,
  input  logic [SET_W-1:0] wr_set,
  input  logic [TAG_W-1:0] wr_tag,
  input  ic_data_t         wr_data
);

  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  ic_data_t         data_q [SETS];

  // Invalidation beats a same-cycle fill, so the filled line stays invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (inv_all) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_set] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_set]  <= wr_tag;
      data_q[wr_set] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_set];
  assign rd_tag   = tag_q[rd_set];
  assign rd_data  = data_q[rd_set];

endmodule

// File: rtl/icache_resp.sv
// Blocking direct-mapped icache answering IFB fetch requests; refills misses with a 4-beat burst.
module icache_resp
  import icache_resp_pkg::*;
#(
  parameter int SETS  = ICACHE_SETS,
  parameter int TAG_W = 32 - 4 - $clog2(SETS),
  parameter int IDX_W = IFB_ENTRY_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  inv_all,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_pc,
  input  logic [IDX_W-1:0]      req_entry_idx,
  output logic                  resp_valid,
  output logic [3:0][31:0]      resp_instr,
  output logic [IDX_W-1:0]      resp_entry_idx,
  output logic                  mem_rd_req,
  output logic [31:0]           mem_rd_addr,
  input  logic                  mem_rd_gnt,
  input  logic                  mem_rd_data_valid,
  input  logic [31:0]           mem_rd_data,
  input  logic                  mem_rd_last
);

  localparam int SET_W = $clog2(SETS);

  ic_state_t         state_q, state_d;
  logic [31:4]       pc_q;
  logic [IDX_W-1:0]  idx_q;
  logic [1:0]        beat_q;
  logic              drop_q;
  logic [2:0][31:0]  buf_q;

  logic [SET_W-1:0]  cur_set;
  logic [TAG_W-1:0]  cur_tag;
  logic              arr_valid;
  logic [TAG_W-1:0]  arr_tag;
  ic_data_t          arr_data;
  logic              hit;
  logic              accept;
  logic              beat_fire;
  logic              fill_done;
  ic_data_t          fill_data;
  logic              unused_pc_lo;

  assign unused_pc_lo = ^req_pc[3:0];

  assign cur_set   = pc_q[4+SET_W-1:4];
  assign cur_tag   = pc_q[31:4+SET_W];
  assign hit       = arr_valid && (arr_tag == cur_tag);
  assign req_ready = (state_q == IC_IDLE) && !flush && !inv_all;
  assign accept    = req_valid && req_ready;
  assign beat_fire = (state_q == IC_REFILL) && mem_rd_data_valid;
  assign fill_done = beat_fire && (beat_q == 2'd3);
  // Beat 3 bypasses the buffer straight into the array and the response.
  assign fill_data = {mem_rd_data, buf_q};
  assign mem_rd_addr = {pc_q, 4'b0000};

  icache_array #(
    .SETS  (SETS),
    .TAG_W (TAG_W)
  ) u_array (
    .clk      (clk),
    .rst_n    (rst_n),
    .inv_all  (inv_all),
    .rd_set   (cur_set),
    .rd_valid (arr_valid),
    .rd_tag   (arr_tag),
    .rd_data  (arr_data),
    .wr_en    (fill_done),
    .wr_set   (cur_set),
    .wr_tag   (cur_tag),
    .wr_data  (fill_data)
  );

  always_comb begin
    state_d    = state_q;
    mem_rd_req = 1'b0;
    unique case (state_q)
      IC_IDLE: begin
        if (accept) state_d = IC_LOOKUP;
      end
      IC_LOOKUP: begin
        if (flush || hit) state_d = IC_IDLE;
        else              state_d = IC_MISS_REQ;
      end
      IC_MISS_REQ: begin
        mem_rd_req = 1'b1;
        if (mem_rd_gnt) state_d = IC_REFILL;
        else if (flush) state_d = IC_IDLE;
      end
      IC_REFILL: begin
        if (fill_done) state_d = IC_IDLE;
      end
      default: state_d = IC_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IC_IDLE;
      pc_q           <= '0;
      idx_q          <= '0;
      beat_q         <= '0;
      drop_q         <= 1'b0;
      buf_q          <= '0;
      resp_valid     <= 1'b0;
      resp_instr     <= '0;
      resp_entry_idx <= '0;
    end else begin
      state_q    <= state_d;
      resp_valid <= 1'b0;
      if (accept) begin
        pc_q  <= req_pc[31:4];
        idx_q <= req_entry_idx;
      end
      if ((state_q == IC_LOOKUP) && !flush && hit) begin
        resp_valid     <= 1'b1;
        resp_instr     <= arr_data;
        resp_entry_idx <= idx_q;
      end
      if ((state_q == IC_MISS_REQ) && mem_rd_gnt) begin
        beat_q <= '0;
        drop_q <= flush;
      end
      if ((state_q == IC_REFILL) && flush) drop_q <= 1'b1;
      if (beat_fire) begin
        beat_q <= beat_q + 2'd1;
        if (beat_q != 2'd3) buf_q[beat_q] <= mem_rd_data;
      end
      if (fill_done && !drop_q && !flush) begin
        resp_valid     <= 1'b1;
        resp_instr     <= fill_data;
        resp_entry_idx <= idx_q;
      end
      if (state_d == IC_IDLE) drop_q <= 1'b0;
    end
  end

  last_on_beat3: assert property (@(posedge clk) disable iff (!rst_n)
    (beat_fire && mem_rd_last) |-> (beat_q == 2'd3));

endmodule

// File: tb/tb_icache_resp.sv
// Scoreboard bench for icache_resp: cache/memory reference model, directed cases then random fetches.
module tb_icache_resp;
  import icache_resp_pkg::*;

  localparam int IDX_W = IFB_ENTRY_WIDTH;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 flush = 1'b0;
  logic                 inv_all = 1'b0;
  logic                 req_valid = 1'b0;
  logic                 req_ready;
  logic [31:0]          req_pc = '0;
  logic [IDX_W-1:0]     req_entry_idx = '0;
  logic                 resp_valid;
  logic [3:0][31:0]     resp_instr;
  logic [IDX_W-1:0]     resp_entry_idx;
  logic                 mem_rd_req;
  logic [31:0]          mem_rd_addr;
  logic                 mem_rd_gnt = 1'b0;
  logic                 mem_rd_data_valid = 1'b0;
  logic [31:0]          mem_rd_data = '0;
  logic                 mem_rd_last = 1'b0;

  icache_resp #(
    .SETS  (64),
    .IDX_W (IDX_W)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .flush             (flush),
    .inv_all           (inv_all),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_pc            (req_pc),
    .req_entry_idx     (req_entry_idx),
    .resp_valid        (resp_valid),
    .resp_instr        (resp_instr),
    .resp_entry_idx    (resp_entry_idx),
    .mem_rd_req        (mem_rd_req),
    .mem_rd_addr       (mem_rd_addr),
    .mem_rd_gnt        (mem_rd_gnt),
    .mem_rd_data_valid (mem_rd_data_valid),
    .mem_rd_data       (mem_rd_data),
    .mem_rd_last       (mem_rd_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0][31:0] instr;
    logic [IDX_W-1:0] idx;
  } exp_t;

  exp_t            sb[$];
  exp_t            mon_e;
  int unsigned     n_chk = 0;
  int unsigned     n_fail = 0;
  bit [31:0]       mem [bit [31:0]];
  bit              mvalid [64];
  bit [21:0]       mtag [64];

  // Modes: 0 plain, 1 flush in lookup, 2 flush before grant, 3 flush after beat 1,
  // 4 flush with grant, 5 inv_all with last beat, 6 reset after beat 1.
  localparam int M_NONE = 0, M_FL_LOOK = 1, M_FL_REQ = 2, M_FL_REFILL = 3,
                 M_FL_GNT = 4, M_INV_LAST = 5, M_RST = 6;

  function automatic logic [3:0][31:0] mline(input bit [31:0] line);
    logic [3:0][31:0] r;
    for (int k = 0; k < 4; k++) begin
      if (!mem.exists(line + 32'(4*k))) mem[line + 32'(4*k)] = $urandom;
      r[k] = mem[line + 32'(4*k)];
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_clear();
    for (int s = 0; s < 64; s++) mvalid[s] = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && resp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_resp: got resp_valid=1 idx=%0d expected no response", resp_entry_idx);
      end else begin
        mon_e = sb.pop_front();
        chk("resp_instr", resp_instr, mon_e.instr);
        chk("resp_entry_idx", 128'(resp_entry_idx), 128'(mon_e.idx));
      end
    end
  end

  task automatic wait_ready();
    for (int i = 0; i < 20; i++) begin
      if (req_ready === 1'b1) return;
      tick();
    end
    n_chk++;
    n_fail++;
    $display("FAIL ready_timeout: got req_ready=0 for 20 cycles expected 1");
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [IDX_W-1:0] idx,
                       input int mode, input int unsigned gnt_dly);
    int unsigned      set;
    bit [21:0]        tg;
    bit               hit;
    bit               resp_exp;
    logic [31:0]      line;
    logic [3:0][31:0] d;
    set  = pc[9:4];
    tg   = pc[31:10];
    hit  = mvalid[set] && (mtag[set] == tg);
    line = {pc[31:4], 4'h0};
    d    = mline(line);

    wait_ready();
    req_valid = 1'b1;
    req_pc = pc;
    req_entry_idx = idx;
    #1 chk("req_ready_idle", 128'(req_ready), 128'(1));
    tick();
    req_valid = 1'b0;

    if (mode == M_FL_LOOK) begin
      flush = 1'b1;
      tick();
      flush = 1'b0;
      #1;
      chk("flush_lookup_no_resp", 128'(resp_valid), 128'(0));
      chk("flush_lookup_no_req", 128'(mem_rd_req), 128'(0));
      chk("flush_lookup_ready", 128'(req_ready), 128'(1));
      return;
    end

    if (hit) begin
      sb.push_back('{d, idx});
      tick();
      #1;
      chk("hit_resp_timing", 128'(resp_valid), 128'(1));
      chk("hit_ready_back", 128'(req_ready), 128'(1));
      chk("hit_no_mem_req", 128'(mem_rd_req), 128'(0));
      return;
    end

    tick();
    #1;
    chk("miss_mem_req", 128'(mem_rd_req), 128'(1));
    chk("miss_mem_addr", 128'(mem_rd_addr), 128'(line));
    chk("miss_no_resp", 128'(resp_valid), 128'(0));
    repeat (gnt_dly) tick();
    if (gnt_dly > 0) chk("miss_req_held", 128'(mem_rd_req), 128'(1));

    if (mode == M_FL_REQ) begin
      flush = 1'b1;
      tick();
      flush = 1'b0;
      #1;
      chk("flush_req_dropped", 128'(mem_rd_req), 128'(0));
      chk("flush_req_ready", 128'(req_ready), 128'(1));
      chk("flush_req_no_resp", 128'(resp_valid), 128'(0));
      return;
    end

    mem_rd_gnt = 1'b1;
    flush = (mode == M_FL_GNT);
    tick();
    mem_rd_gnt = 1'b0;
    flush = 1'b0;
    #1;
    chk("gnt_req_released", 128'(mem_rd_req), 128'(0));
    chk("refill_not_ready", 128'(req_ready), 128'(0));

    resp_exp = (mode == M_NONE) || (mode == M_INV_LAST);
    for (int b = 0; b < 4; b++) begin
      repeat ($urandom_range(0, 2)) tick();
      mem_rd_data_valid = 1'b1;
      mem_rd_data = d[b];
      mem_rd_last = (b == 3);
      inv_all = (mode == M_INV_LAST) && (b == 3);
      if (b == 3 && resp_exp) sb.push_back('{d, idx});
      tick();
      mem_rd_data_valid = 1'b0;
      mem_rd_last = 1'b0;
      inv_all = 1'b0;
      if (b == 1 && mode == M_FL_REFILL) begin
        flush = 1'b1;
        tick();
        flush = 1'b0;
      end
      if (b == 1 && mode == M_RST) begin
        rst_n = 1'b0;
        #1;
        chk("rst_resp_valid", 128'(resp_valid), 128'(0));
        chk("rst_resp_instr", resp_instr, 128'(0));
        chk("rst_resp_idx", 128'(resp_entry_idx), 128'(0));
        chk("rst_mem_req", 128'(mem_rd_req), 128'(0));
        chk("rst_mem_addr", 128'(mem_rd_addr), 128'(0));
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    #1;
    chk("refill_ready_back", 128'(req_ready), 128'(1));
    chk("refill_resp_timing", 128'(resp_valid), 128'(resp_exp));
    chk("refill_no_mem_req", 128'(mem_rd_req), 128'(0));

    if (mode == M_INV_LAST) model_clear();
    else if (mode != M_RST) begin
      mvalid[set] = 1'b1;
      mtag[set] = tg;
    end
  endtask

  task automatic pulse_inv();
    @(negedge clk);
    inv_all = 1'b1;
    #1 chk("inv_blocks_ready", 128'(req_ready), 128'(0));
    tick();
    inv_all = 1'b0;
    model_clear();
  endtask

  initial begin
    #300000;
    n_fail++;
    $display("FAIL watchdog: got no end of test expected finish before time limit");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1);
  end

  initial begin
    model_clear();
    mem[32'h1C00_0000] = 32'h11;
    mem[32'h1C00_0004] = 32'h22;
    mem[32'h1C00_0008] = 32'h33;
    mem[32'h1C00_000C] = 32'h44;

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_req_ready", 128'(req_ready), 128'(1));
    chk("reset_resp_valid", 128'(resp_valid), 128'(0));
    chk("reset_resp_instr", resp_instr, 128'(0));
    chk("reset_resp_idx", 128'(resp_entry_idx), 128'(0));
    chk("reset_mem_req", 128'(mem_rd_req), 128'(0));
    chk("reset_mem_addr", 128'(mem_rd_addr), 128'(0));
    @(negedge clk);

    fetch(32'h1C00_0000, 4'd3, M_NONE, 1);
    fetch(32'h1C00_000C, 4'd4, M_NONE, 0);
    fetch(32'h1C00_0400, 4'd5, M_NONE, 0);
    fetch(32'h1C00_0000, 4'd6, M_NONE, 2);
    fetch(32'h1C00_0800, 4'd7, M_FL_REFILL, 0);
    fetch(32'h1C00_0804, 4'd8, M_NONE, 0);
    fetch(32'h1C00_0800, 4'd9, M_FL_LOOK, 0);
    fetch(32'h1C00_1000, 4'd1, M_FL_REQ, 2);
    fetch(32'h1C00_1000, 4'd2, M_FL_GNT, 0);
    fetch(32'h1C00_1008, 4'd10, M_NONE, 0);
    fetch(32'h1C00_2000, 4'd11, M_RST, 0);
    fetch(32'h1C00_0000, 4'd12, M_NONE, 0);
    pulse_inv();
    fetch(32'h1C00_0000, 4'd13, M_NONE, 0);
    fetch(32'h1C00_3000, 4'd14, M_INV_LAST, 1);
    fetch(32'h1C00_3000, 4'd15, M_NONE, 0);

    @(negedge clk);
    flush = 1'b1;
    #1 chk("flush_blocks_ready", 128'(req_ready), 128'(0));
    tick();
    flush = 1'b0;

    for (int i = 0; i < 120; i++) begin
      logic [31:0] pc;
      int unsigned r;
      int          mode;
      pc = {22'h070000 + 22'($urandom_range(0, 2)), 6'($urandom_range(0, 3)), 4'($urandom)};
      r = $urandom_range(0, 11);
      case (r)
        6: mode = M_FL_LOOK;
        7: mode = M_FL_REQ;
        8: mode = M_FL_REFILL;
        9: mode = M_FL_GNT;
        10: mode = M_INV_LAST;
        default: mode = M_NONE;
      endcase
      if ($urandom_range(0, 19) == 0) pulse_inv();
      fetch(pc, IDX_W'($urandom), mode, $urandom_range(0, 3));
    end

    repeat (3) tick();
    chk("scoreboard_drained", 128'(sb.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
